// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter and sequencer for a single-port block memory.
// Zero-fills the memory after reset, then serves fetch and load/store.
module bram_port_arbiter #(
    parameter int AW             = 10,
    parameter int DW             = 16,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          init_done
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [0:0] S_RST  = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic          last_gnt;
    logic          run;

    assign run = (state == S_RUN) & ~rst;

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (run) begin
            unique case (1'b1)
                (req0 & ~req1): gnt0 = 1'b1;
                (req1 & ~req0): gnt1 = 1'b1;
                (req0 & req1): begin
                    gnt0 = last_gnt;
                    gnt1 = ~last_gnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr0;
        mem_din  = wdata0;
        if (state == S_INIT) begin
            mem_we   = ~rst;
            mem_addr = clr_cnt;
            mem_din  = '0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
        end else begin
            mem_we   = gnt0 & we0;
        end
    end

    assign rdata0 = mem_dout;
    assign rdata1 = mem_dout;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= S_RST;
            clr_cnt   <= '0;
            last_gnt  <= 1'b1;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 | gnt1) begin
                last_gnt <= gnt1;
            end
            if (state == S_INIT) begin
                clr_cnt <= clr_cnt + AW'(1);
                if (clr_cnt == LAST) begin
                    state     <= S_RUN;
                    init_done <= 1'b1;
                end
            end else begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: memory model, reference model and
// directed scenarios for clear, access, contention and reset.
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic        init_done;

    logic        b_rst;
    logic        b_req0, b_req1, b_we0, b_we1;
    logic [9:0]  b_addr0, b_addr1;
    logic [15:0] b_wdata0, b_wdata1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [15:0] b_rdata0, b_rdata1;
    logic        b_mem_we;
    logic [9:0]  b_mem_addr;
    logic [15:0] b_mem_din, b_mem_dout;
    logic        b_init_done;

    bram_port_arbiter u0 (
        .clka(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .init_done(init_done)
    );

    bram_port_arbiter #(.CLEAR_ON_RESET(0)) u1 (
        .clka(clk), .rst(b_rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1),
        .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1),
        .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .mem_dout(b_mem_dout), .init_done(b_init_done)
    );

    // Block memories, read-first, with a bench-side preload port.
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (mem_we) mem_a[mem_addr] <= mem_din;
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_din;
        end
        mem_dout   <= mem_a[mem_addr];
        b_mem_dout <= mem_b[b_mem_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: clear phase length, round-robin, word store.
    int          m_n = 0;
    int          m_last = 1;
    bit          m_pend = 0;
    int          m_pwho = 0;
    logic [15:0] m_pdat;
    logic [15:0] refm [1024];
    int          g;
    logic        gwe;
    logic [9:0]  gad;
    logic [15:0] gd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_gnt0", 32'(gnt0), 0);
            chk("rst_gnt1", 32'(gnt1), 0);
            chk("rst_rvalid0", 32'(rvalid0), 0);
            chk("rst_rvalid1", 32'(rvalid1), 0);
            chk("rst_init_done", 32'(init_done), 0);
            m_n = 0;
            m_pend = 0;
            m_last = 1;
        end else if (m_n < 1024) begin
            chk("clr_mem_we", 32'(mem_we), 1);
            chk("clr_addr", 32'(mem_addr), 32'(m_n));
            chk("clr_din", 32'(mem_din), 0);
            chk("clr_gnt", 32'({gnt1, gnt0}), 0);
            chk("clr_rvalid", 32'({rvalid1, rvalid0}), 0);
            chk("clr_init_done", 32'(init_done), 0);
            refm[m_n] = 16'h0000;
            m_n++;
        end else begin
            if (req0 && req1) g = (m_last == 1) ? 0 : 1;
            else if (req0) g = 0;
            else if (req1) g = 1;
            else g = -1;
            chk("run_init_done", 32'(init_done), 1);
            chk("run_gnt0", 32'(gnt0), 32'(g == 0));
            chk("run_gnt1", 32'(gnt1), 32'(g == 1));
            chk("run_rvalid0", 32'(rvalid0), 32'(m_pend && m_pwho == 0));
            chk("run_rvalid1", 32'(rvalid1), 32'(m_pend && m_pwho == 1));
            if (m_pend)
                chk("run_rdata", 32'(m_pwho == 0 ? rdata0 : rdata1), 32'(m_pdat));
            m_pend = 0;
            if (g >= 0) begin
                gwe = (g == 0) ? we0 : we1;
                gad = (g == 0) ? addr0 : addr1;
                gd  = (g == 0) ? wdata0 : wdata1;
                chk("run_mem_we", 32'(mem_we), 32'(gwe));
                chk("run_mem_addr", 32'(mem_addr), 32'(gad));
                if (gwe) begin
                    chk("run_mem_din", 32'(mem_din), 32'(gd));
                    refm[gad] = gd;
                end else begin
                    m_pend = 1;
                    m_pwho = g;
                    m_pdat = refm[gad];
                end
                m_last = g;
            end else begin
                chk("idle_mem_we", 32'(mem_we), 0);
            end
        end
    end

    task automatic acc(input int who, input logic we, input logic [9:0] a,
                       input logic [15:0] d, output int waited);
        bit ok;
        ok = 0;
        waited = -1;
        if (who == 0) begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = d;
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((who == 0) ? gnt0 : gnt1) begin
                ok = 1;
                waited = i;
                break;
            end
        end
        chk("acc_granted", 32'(ok), 1);
        @(posedge clk);
        #1;
        if (who == 0) req0 = 0;
        else req1 = 0;
    endtask

    task automatic count_init(output int c, output int fa);
        bit seen;
        seen = 0;
        c = 0;
        fa = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) fa = int'(mem_addr);
            if (init_done) begin
                seen = 1;
                break;
            end
            if (mem_we) c++;
        end
        chk("init_done_seen", 32'(seen), 1);
    endtask

    int          w, c, fa, bcnt;
    logic [3:0]  gs;

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_rst = 1; b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;

        @(posedge clk); #1;
        pl_en = 1; pl_addr = 10'd8; pl_data = 16'h00AA;
        @(posedge clk); #1;
        pl_addr = 10'd5; pl_data = 16'h5555;
        @(posedge clk); #1;
        pl_en = 0;
        @(negedge clk);
        chk("b_rst_init_done", 32'(b_init_done), 0);
        @(posedge clk); #1;

        // Clear after reset, with a fetch read held across the clear.
        rst = 0;
        fork
            count_init(c, fa);
            acc(0, 1'b0, 10'd8, 16'h0, w);
        join
        chk("init_we_cycles", 32'(c), 1024);
        chk("init_first_addr", 32'(fa), 0);
        chk("init_rd_wait", 32'(w), 1024);
        @(negedge clk);
        chk("init_rd_valid", 32'(rvalid0), 1);
        chk("init_rd_data", 32'(rdata0), 32'h0000);
        @(posedge clk); #1;

        // Single write then read.
        acc(0, 1'b1, 10'd8, 16'h0010, w);
        chk("wr_same_cycle", 32'(w), 0);
        acc(0, 1'b0, 10'd8, 16'h0, w);
        @(negedge clk);
        chk("rd_valid0", 32'(rvalid0), 1);
        chk("rd_data0", 32'(rdata0), 32'h0010);
        chk("rd_valid1", 32'(rvalid1), 0);
        @(posedge clk); #1;

        // Contention; last grant left with requester 1.
        acc(0, 1'b1, 10'd1, 16'h1111, w);
        acc(1, 1'b1, 10'd2, 16'h2222, w);
        req0 = 1; we0 = 0; addr0 = 10'd1;
        req1 = 1; we1 = 0; addr1 = 10'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gs[k] = gnt1;
            chk("cont_one_gnt", 32'(gnt0 ^ gnt1), 1);
            if (k == 1 || k == 3) begin
                chk("cont_rv0", 32'({rvalid1, rvalid0}), 32'b01);
                chk("cont_rd0", 32'(rdata0), 32'h1111);
            end else if (k == 2) begin
                chk("cont_rv1", 32'({rvalid1, rvalid0}), 32'b10);
                chk("cont_rd1", 32'(rdata1), 32'h2222);
            end
            @(posedge clk); #1;
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("cont_order", 32'(gs), 32'b1010);
        chk("cont_rv_last", 32'({rvalid1, rvalid0}), 32'b10);
        chk("cont_rd_last", 32'(rdata1), 32'h2222);
        @(posedge clk); #1;

        // Back-to-back on requester 1.
        for (int i = 0; i < 8; i++) begin
            req1 = 1; we1 = (i < 4); addr1 = 10'(i % 4);
            wdata1 = 16'hB000 + 16'(i);
            @(negedge clk);
            chk("b2b_gnt1", 32'(gnt1), 1);
            if (i >= 5) begin
                chk("b2b_rv", 32'(rvalid1), 1);
                chk("b2b_rd", 32'(rdata1), 32'(16'hB000 + 16'(i - 5)));
            end
            @(posedge clk); #1;
        end
        req1 = 0;
        @(negedge clk);
        chk("b2b_rv_end", 32'(rvalid1), 1);
        chk("b2b_rd_end", 32'(rdata1), 32'hB003);
        @(posedge clk); #1;

        // Reset in the middle of the clear.
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (501) @(negedge clk);
        chk("mid_clr_addr", 32'(mem_addr), 500);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("mid_clr_we_off", 32'(mem_we), 0);
        @(posedge clk); #1;
        rst = 0;
        count_init(c, fa);
        chk("restart_we_cycles", 32'(c), 1024);
        chk("restart_first_addr", 32'(fa), 0);
        @(posedge clk); #1;

        // Reset right after a read grant.
        acc(0, 1'b0, 10'd8, 16'h0, w);
        chk("mr_rv_before", 32'(rvalid0), 1);
        rst = 1;
        #1;
        chk("mr_rv_cleared", 32'(rvalid0), 0);
        @(posedge clk); #1;
        rst = 0;
        count_init(c, fa);
        chk("mr_restart_cycles", 32'(c), 1024);
        @(posedge clk); #1;

        // Instance without the clear sequence.
        b_rst = 0;
        b_req0 = 1; b_we0 = 0; b_addr0 = 10'd5;
        bcnt = 0;
        @(negedge clk);
        chk("nc_gnt0", 32'(b_gnt0), 1);
        chk("nc_init_done_pre", 32'(b_init_done), 0);
        if (b_mem_we) bcnt++;
        @(posedge clk); #1;
        b_req0 = 0;
        @(negedge clk);
        chk("nc_init_done", 32'(b_init_done), 1);
        chk("nc_rvalid0", 32'(b_rvalid0), 1);
        chk("nc_rdata0", 32'(b_rdata0), 32'h5555);
        if (b_mem_we) bcnt++;
        repeat (3) begin
            @(negedge clk);
            if (b_mem_we) bcnt++;
        end
        chk("nc_no_clear", 32'(bcnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
